psum_drain_unit: RTL and testbench

- Downstream stage of the systolic array top level. Consumes the per-column result vector (outs_array, one width-bit lane per column).
- Accumulates partial sums across K tiles in signed saturating fixed point, then moves the finished vector into a drain bank.
- Serialises the drain bank one value per handshake to the write-back path.
- Double-banked (accumulate bank + drain bank), so the next tile's accumulation overlaps draining of the previous result.

---
 rtl/psum_drain_unit.sv | 144 ++++++++++++++
 tb/tb_psum_drain_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain_unit.sv
// Partial-sum accumulator with a double-banked drain that serialises one lane per handshake.
// Optional build macro PSUM_DRAIN_RELU_EN applies ReLU to each lane as it enters the drain bank.
module psum_drain_unit #(
  parameter int width   = 16,
  parameter int decimal = 8,
  parameter int cols    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_en,
  input  logic                  acc_clr,
  input  logic                  last,
  input  logic [cols*width-1:0] outs_array,
  output logic                  stall,
  output logic [width-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  overflow
);

  localparam int LW = (cols > 1) ? $clog2(cols) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(cols - 1);
  localparam logic [width-1:0] SAT_MAX = {1'b0, {(width-1){1'b1}}};
  localparam logic [width-1:0] SAT_MIN = {1'b1, {(width-1){1'b0}}};

  if (decimal < 0 || decimal >= width) begin : g_bad_decimal
    $error("decimal must lie in [0, width-1]");
  end

  typedef enum logic {IDLE, DRAIN} state_t;

  // Returns {clamped, result}; the add is done one bit wider so overflow is just a sign disagreement.
  function automatic logic [width:0] sat_add(input logic [width-1:0] a, input logic [width-1:0] b);
    logic [width:0] s;
    s = {a[width-1], a} + {b[width-1], b};
    if (s[width] != s[width-1]) begin
      sat_add = {1'b1, (s[width] ? SAT_MIN : SAT_MAX)};
    end else begin
      sat_add = {1'b0, s[width-1:0]};
    end
  endfunction

  function automatic logic [width-1:0] relu(input logic [width-1:0] a);
`ifdef PSUM_DRAIN_RELU_EN
    relu = a[width-1] ? '0 : a;
`else
    relu = a;
`endif
  endfunction

  state_t             state_q, state_d;
  logic [LW-1:0]      lane_q, lane_d;
  logic [width-1:0]   acc_q   [cols];
  logic [width-1:0]   acc_d   [cols];
  logic [width-1:0]   drain_q [cols];
  logic [width-1:0]   drain_d [cols];
  logic [width-1:0]   out_data_q, out_data_d;
  logic               ovf_q, ovf_d;

  logic               hs, last_hs, accept, transfer;
  logic [width-1:0]   final_v [cols];
  logic [cols-1:0]    clamp;

  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == DRAIN);
  assign out_data  = out_data_q;
  assign overflow  = ovf_q;

  // A last-tile capture may only land if the drain bank is free or frees up on this very edge.
  always_comb begin
    hs       = out_valid & out_ready;
    last_hs  = hs & (lane_q == LAST_LANE);
    stall    = cap_en & last & busy & ~last_hs;
    accept   = cap_en & ~stall;
    transfer = accept & last;
    for (int i = 0; i < cols; i++) begin
      if (acc_clr) begin
        {clamp[i], final_v[i]} = {1'b0, outs_array[i*width +: width]};
      end else begin
        {clamp[i], final_v[i]} = sat_add(acc_q[i], outs_array[i*width +: width]);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    acc_d      = acc_q;
    drain_d    = drain_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q | (accept & (|clamp));

    if (transfer) begin
      for (int i = 0; i < cols; i++) begin
        acc_d[i]   = '0;
        drain_d[i] = relu(final_v[i]);
      end
      out_data_d = relu(final_v[0]);
      state_d    = DRAIN;
      lane_d     = '0;
    end else if (accept) begin
      acc_d = final_v;
    end else begin
      acc_d = acc_q;
    end

    // A transfer coinciding with the final handshake already reloaded lane 0 above.
    if (!transfer) begin
      if (last_hs) begin
        state_d = IDLE;
        lane_d  = '0;
      end else if (hs) begin
        lane_d     = lane_q + LW'(1);
        out_data_d = drain_q[lane_q + LW'(1)];
      end else begin
        lane_d = lane_q;
      end
    end else begin
      lane_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < cols; i++) begin
        acc_q[i]   <= '0;
        drain_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
      acc_q      <= acc_d;
      drain_q    <= drain_d;
    end
  end

endmodule

// File: tb/tb_psum_drain_unit.sv
// Self-checking bench: a queue-based reference model of accumulate/drain behaviour plus directed literal checks.
module tb_psum_drain_unit;
  localparam int W = 16;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cap_en = 1'b0, acc_clr = 1'b0, last = 1'b0, out_ready = 1'b0;
  logic [C*W-1:0] outs_array = '0;
  logic           stall, out_valid, busy, overflow;
  logic [W-1:0]   out_data;

  psum_drain_unit #(.width(W), .decimal(8), .cols(C)) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .acc_clr(acc_clr), .last(last),
    .outs_array(outs_array), .stall(stall), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          acc_m [C];
  logic [W-1:0] q_m[$];
  logic [W-1:0] beats[$];
  logic        ovf_m = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q_m.delete();
    for (int i = 0; i < C; i++) acc_m[i] = 0;
    ovf_m = 1'b0;
  endtask

  function automatic int lane_val(input logic [C*W-1:0] v, input int i);
    logic [W-1:0] t;
    t = v[i*W +: W];
    return int'($signed(t));
  endfunction

  // One clock: compare against the model just before the edge, then advance the model.
  task automatic tick();
    int  sz, v, fin[C];
    logic hs_m, stall_m;
    @(negedge clk);
    sz      = q_m.size();
    hs_m    = (sz > 0) && out_ready;
    stall_m = cap_en && last && (sz > 0) && !(hs_m && sz == 1);
    chk("out_valid", 32'(out_valid), 32'(sz > 0));
    chk("busy", 32'(busy), 32'(sz > 0));
    chk("stall", 32'(stall), 32'(stall_m));
    chk("overflow", 32'(overflow), 32'(ovf_m));
    if (sz > 0) chk("out_data", 32'(out_data), 32'(q_m[0]));
    if (hs_m) begin
      beats.push_back(q_m[0]);
      void'(q_m.pop_front());
    end
    if (cap_en && !stall_m) begin
      for (int i = 0; i < C; i++) begin
        v = acc_clr ? lane_val(outs_array, i) : acc_m[i] + lane_val(outs_array, i);
        if (v > 32767)  begin v = 32767;  ovf_m = 1'b1; end
        if (v < -32768) begin v = -32768; ovf_m = 1'b1; end
        fin[i] = v;
      end
      for (int i = 0; i < C; i++) begin
        if (last) begin
`ifdef PSUM_DRAIN_RELU_EN
          if (fin[i] < 0) fin[i] = 0;
`endif
          q_m.push_back(W'(fin[i]));
          acc_m[i] = 0;
        end else begin
          acc_m[i] = fin[i];
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ce, input logic clr, input logic lst,
                       input logic [C*W-1:0] d, input logic rdy);
    cap_en = ce; acc_clr = clr; last = lst; outs_array = d; out_ready = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 1'b0, 1'b0, '0, rdy);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    model_clear();
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [C*W-1:0] va, vb;
  logic [W-1:0]   neg_exp;

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data", 32'(out_data), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;

    // Single tile
    beats.delete();
    drive(1'b1, 1'b1, 1'b1, {16'h0080, 16'hFF00, 16'h0200, 16'h0100}, 1'b1);
    tick();
    idle(1'b1);
    chk("single_valid_rise", 32'(out_valid), 32'd1);
    repeat (4) tick();
    chk("single_b0", 32'(beats[0]), 32'h0100);
    chk("single_b1", 32'(beats[1]), 32'h0200);
`ifdef PSUM_DRAIN_RELU_EN
    chk("single_b2", 32'(beats[2]), 32'h0000);
`else
    chk("single_b2", 32'(beats[2]), 32'hFF00);
`endif
    chk("single_b3", 32'(beats[3]), 32'h0080);
    chk("single_idle", 32'(busy), 32'd0);

    // Three-tile accumulate
    beats.delete();
    drive(1'b1, 1'b1, 1'b0, 64'h0100, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b0, 64'h0100, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b1, 64'h0080, 1'b1); tick();
    idle(1'b1);
    repeat (4) tick();
    chk("acc3_b0", 32'(beats[0]), 32'h0280);
    chk("acc3_ovf", 32'(overflow), 32'd0);

    // Positive then negative saturation
    beats.delete();
    drive(1'b1, 1'b1, 1'b0, 64'h7000, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b1, 64'h2000, 1'b1); tick();
    idle(1'b1);
    repeat (4) tick();
    chk("sat_pos", 32'(beats[0]), 32'h7FFF);
    chk("sat_ovf", 32'(overflow), 32'd1);
    beats.delete();
    drive(1'b1, 1'b1, 1'b0, 64'h9000, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b1, 64'hA000, 1'b1); tick();
    idle(1'b1);
    repeat (4) tick();
`ifdef PSUM_DRAIN_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'h8000;
`endif
    chk("sat_neg", 32'(beats[0]), 32'(neg_exp));
    chk("sat_ovf_sticky", 32'(overflow), 32'd1);

    // Backpressure at lane 1
    beats.delete();
    va = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    drive(1'b1, 1'b1, 1'b1, va, 1'b1); tick();
    idle(1'b1); tick();
    idle(1'b0);
    repeat (5) tick();
    chk("bp_hold_data", 32'(out_data), 32'h0002);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    idle(1'b1);
    repeat (3) tick();
    chk("bp_b1", 32'(beats[1]), 32'h0002);
    chk("bp_b3", 32'(beats[3]), 32'h0004);

    // Stall during drain, then back-to-back acceptance on the final handshake
    beats.delete();
    vb = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
    drive(1'b1, 1'b1, 1'b1, va, 1'b1); tick();
    idle(1'b1); tick();
    drive(1'b1, 1'b0, 1'b1, vb, 1'b0);
    #1 chk("stall_lane1", 32'(stall), 32'd1);
    tick();
    drive(1'b1, 1'b0, 1'b1, vb, 1'b1);
    tick(); tick();
    chk("b2b_no_stall", 32'(stall), 32'd0);
    tick();
    idle(1'b1);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_first", 32'(out_data), 32'h0010);
    repeat (4) tick();
    chk("b2b_b3", 32'(beats[3]), 32'h0004);
    chk("b2b_b7", 32'(beats[7]), 32'h0040);

    // Async reset mid-drain, then a fresh tile
    drive(1'b1, 1'b1, 1'b1, va, 1'b1); tick();
    idle(1'b1); tick();
    async_reset();
    beats.delete();
    drive(1'b1, 1'b1, 1'b1, vb, 1'b1); tick();
    idle(1'b1);
    repeat (4) tick();
    chk("post_rst_b0", 32'(beats[0]), 32'h0010);
    chk("post_rst_b3", 32'(beats[3]), 32'h0040);

    // Randomised traffic against the model
    for (int n = 0; n < 2000; n++) begin
      logic [C*W-1:0] d;
      d = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < C; i++) d[i*W +: W] = W'($urandom_range(0, 1023)) - W'(512);
      end
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 2) == 0), d, 1'($urandom_range(0, 3) != 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
